// File: rtl/mul8_mac_acc_if.sv
// rtl/mul8_mac_acc_if.sv - operand/result handshake bundle for mul8_mac_acc
//
// Purpose: carries the operand stream into the MAC and the block result out of it.
// Signals:
//   in_valid/in_ready/in_a/in_b         operand pair handshake (8-bit unsigned a, b)
//   out_valid/out_ready/out_data/out_ovf block result handshake (ACC_W-bit sum, overflow flag)
// Modports:
//   slave  - the MAC block (consumes operands, produces results)
//   master - the producer/consumer side (drives operands, accepts results)
interface mul8_mac_acc_if #(
  parameter int ACC_W = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mul8_mac_acc.sv
// rtl/mul8_mac_acc.sv - pipelined 8x8 multiply-accumulate over ACC_LEN beats
//
// Purpose: registers operand pairs (S1), multiplies them with mul8_lrtl, registers
// the 16-bit product (S2), and sums ACC_LEN products into one block result that is
// held on the output handshake until accepted.
// Parameters:
//   ACC_LEN  products summed per output block (>=1)
//   ACC_W    accumulator/output width (>=16)
// Ports:
//   clk      clock, all state on rising edge
//   rst      synchronous active-high reset
//   bus      mul8_mac_acc_if.slave (in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_data/out_ovf)
// Build option:
//   MUL8_MAC_SAT_EN  when defined the accumulator saturates at 2^ACC_W-1 after a carry
//                    and stays there for the rest of the block; otherwise it wraps.

module mul8_lrtl (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = {8'b0, a} * {8'b0, b};
endmodule

module mul8_mac_acc #(
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 19
) (
  input  logic               clk,
  input  logic               rst,
  mul8_mac_acc_if.slave      bus
);
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

  logic             stall;
  logic             s1_valid;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic [15:0]      prod;
  logic             s2_valid;
  logic [15:0]      s2_prod;
  logic [ACC_W-1:0] acc;
  logic             sticky;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic             out_ovf_q;

  logic [ACC_W:0]   sum_wide;
  logic             ovf_next;
  logic [ACC_W-1:0] acc_next;
  logic             complete;

  // A held, unaccepted result freezes the whole pipeline so nothing is lost.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~rst;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  mul8_lrtl u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  always_comb begin
    sum_wide = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, s2_prod};
    ovf_next = sticky | sum_wide[ACC_W];
`ifdef MUL8_MAC_SAT_EN
    // Once the block has carried, pin at full scale until the block closes.
    acc_next = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_next = sum_wide[ACC_W-1:0];
`endif
    complete = ~stall & s2_valid & (cnt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_a        <= 8'd0;
      s1_b        <= 8'd0;
      s2_valid    <= 1'b0;
      s2_prod     <= 16'd0;
      acc         <= '0;
      sticky      <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (!stall) begin
        // in_ready is necessarily high here (not stalled, not in reset).
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a <= bus.in_a;
          s1_b <= bus.in_b;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_prod <= prod;
        end
        if (s2_valid) begin
          if (cnt == LAST_BEAT) begin
            // Close the block and restart from zero in the same edge: no bubble.
            out_data_q <= acc_next;
            out_ovf_q  <= ovf_next;
            acc        <= '0;
            sticky     <= 1'b0;
            cnt        <= '0;
          end else begin
            acc    <= acc_next;
            sticky <= ovf_next;
            cnt    <= cnt + 1'b1;
          end
        end
      end
      // A completion in the same edge as an accept keeps out_valid high.
      if (complete) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mul8_mac_acc.md
Name: mul8_mac_acc

Overview:
Pipelined multiply-accumulate stage wrapped around the existing combinational mul8_lrtl 8x8 unsigned multiplier. It accepts operand pairs over a valid/ready handshake and registers them into the multiplier. It registers the 16-bit product and sums ACC_LEN consecutive products into one block result. The block result is presented on a held valid/ready output towards the downstream consumer (filter/correlator datapath).

Parameters:
ACC_LEN, 8, number of products summed per output block (>=1).
ACC_W, 19, accumulator/output width (>=16); default holds 8 x 255*255 without overflow.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands this cycle.
in_a  input  8  unsigned multiplicand.
in_b  input  8  unsigned multiplier.
out_valid  output  1  out_data/out_ovf hold a completed block.
out_ready  input  1  downstream accepts the result.
out_data  output  ACC_W  block sum of ACC_LEN products.
out_ovf  output  1  accumulation of this block exceeded 2^ACC_W-1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: out_valid=0, out_data=0, out_ovf=0, accumulator=0, beat counter=0, S1/S2 valid=0. in_ready=0 while rst=1.
- stall = out_valid & ~out_ready. in_ready = ~stall & ~rst. While stalled, all pipeline registers, the counter and the accumulator hold.
- Pipeline, no stall:
  - S1 captures in_a/in_b at the edge where in_valid&in_ready.
  - mul8_lrtl is driven from the S1 registers; its 16-bit product is captured into S2 at the next edge.
  - S2 is added into the accumulator at the following edge.
- Latency: out_valid rises 3 cycles after acceptance of the block's last beat.
- Counter 0..ACC_LEN-1 advances on each S2-valid add.
- On the last beat:
  - out_data <= acc + product (ACC_W-bit).
  - out_ovf <= the block's sticky carry.
  - out_valid <= 1.
  - Accumulator, sticky carry and counter clear in the same edge, so the next block starts with no bubble.
- Output: out_valid and out_data stay stable until out_valid&out_ready. out_valid drops on that edge unless a new block completes in the same edge; the new result then loads and out_valid stays 1.
- Gaps: in_valid=0 inserts bubbles; partial blocks wait indefinitely.
- Products are unsigned 16-bit. The add is zero-extended to ACC_W+1 bits; bit ACC_W sets the sticky carry.
- rst mid-block discards the partial sum and any pending output; no result is emitted.
- ACC_LEN=1: every beat produces one output equal to a*b.

Optional Feature:
MUL8_MAC_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1 on carry and holds there for the rest of the block; out_ovf is still reported.
- Undefined: the accumulator wraps modulo 2^ACC_W; out_ovf is still reported.

Test Plan:
- Reset, then 8 beats a=255,b=255, out_ready=1: out_data=520200, out_ovf=0, out_valid 3 cycles after the last beat.
- 8 beats a=k (k=1..8), b=1, back-to-back with a second identical block: two results of 36, no idle cycle between the blocks at the input.
- Hold out_ready=0 after the first result: in_ready drops. Feed 8 more beats gated by in_ready: first result is stable until accepted, second result is 36, no beat is lost.
- Apply rst after 5 beats of a=b=10, then 8 beats a=2,b=3: only one output, 48; no output from the aborted block.
- ACC_W=17, 8 beats a=b=255: without the macro out_data=126984 and out_ovf=1; with MUL8_MAC_SAT_EN out_data=131071 and out_ovf=1.
- ACC_LEN=1, random a/b with random in_valid and out_ready: each out_data equals a*b in order (scoreboard).
